// File: rtl/ps2_kbd_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx_fifo
// Brief    : PS/2 keyboard receiver with glitch filter, frame checker,
//            E0/F0 prefix decoder and an event FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx_fifo #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  output logic [7:0]                    ev_code,
  output logic                          ev_break,
  output logic                          ev_ext,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int c_aw  = $clog2(FIFO_DEPTH);
  localparam int c_fcw = $clog2(FILTER_LEN + 1);
  localparam int c_tcw = $clog2(TIMEOUT_CYC + 1);

  localparam logic [c_fcw-1:0] c_filt_last = c_fcw'(FILTER_LEN - 1);
  localparam logic [c_tcw-1:0] c_to_last   = c_tcw'(TIMEOUT_CYC - 1);
  localparam logic [c_aw:0]    c_depth     = (c_aw + 1)'(FIFO_DEPTH);

  localparam logic [7:0] c_pfx_ext = 8'hE0;
  localparam logic [7:0] c_pfx_brk = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronizers (idle-high lines reset to 1)
  // --------------------------------------------------------------------------
  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       w_clk_s;
  logic       w_dat_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
    end
  end

  assign w_clk_s = clk_sync_q[1];
  assign w_dat_s = dat_sync_q[1];

  // --------------------------------------------------------------------------
  // Clock filter: filt_cnt_q counts consecutive samples that disagree with
  // the filtered level; the FILTER_LEN-th one flips the level.
  // --------------------------------------------------------------------------
  logic             filt_q;
  logic             filt_d;
  logic [c_fcw-1:0] filt_cnt_q;
  logic [c_fcw-1:0] filt_cnt_d;
  logic             w_strobe;

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    w_strobe   = 1'b0;
    if (w_clk_s != filt_q) begin
      if (filt_cnt_q == c_filt_last) begin
        filt_d   = w_clk_s;
        w_strobe = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [2:0]       bit_cnt_q;
  logic [2:0]       bit_cnt_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             par_q;
  logic             par_d;
  logic [c_tcw-1:0] to_cnt_q;
  logic [c_tcw-1:0] to_cnt_d;
  logic             w_good;
  logic             w_err;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = '0;
    w_good    = 1'b0;
    w_err     = 1'b0;

    if (state_q != S_IDLE && !w_strobe) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (w_strobe && !w_dat_s) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (w_strobe) begin
          shift_d   = {w_dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (w_strobe) begin
          par_d   = w_dat_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (w_strobe) begin
          state_d = S_IDLE;
          if ((^shift_q ^ par_q) && w_dat_s) begin
            w_good = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The line stalled mid-frame: give up on the partial byte.
    if (state_q != S_IDLE && !w_strobe && to_cnt_q == c_to_last) begin
      state_d  = S_IDLE;
      w_err    = 1'b1;
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Byte hand-off and prefix decode
  // --------------------------------------------------------------------------
  logic       byte_vld_q;
  logic [7:0] byte_q;
  logic       frame_err_q;
  logic       ext_q;
  logic       ext_d;
  logic       brk_q;
  logic       brk_d;
  logic       w_push;
  logic [9:0] w_push_data;

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    w_push      = 1'b0;
    w_push_data = {ext_q, brk_q, byte_q};
    if (byte_vld_q) begin
      if (byte_q == c_pfx_ext) begin
        ext_d = 1'b1;
      end else if (byte_q == c_pfx_brk) begin
        brk_d = 1'b1;
      end else begin
        w_push = 1'b1;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end
    end
    if (w_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_vld_q  <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      byte_vld_q  <= w_good;
      byte_q      <= shift_q;
      frame_err_q <= w_err;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
    end
  end

  // --------------------------------------------------------------------------
  // Event FIFO
  // --------------------------------------------------------------------------
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [c_aw-1:0] wr_ptr_q;
  logic [c_aw-1:0] rd_ptr_q;
  logic [c_aw:0]   count_q;
  logic            ovf_q;
  logic            w_full;
  logic            w_pop;
  logic            w_wr;

  assign w_full = (count_q == c_depth);
  assign w_pop  = ev_valid && ev_ready;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (w_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (w_push && !w_wr) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= w_push_data;
    end
  end

  assign ev_valid   = (count_q != '0);
  assign {ev_ext, ev_break, ev_code} = ev_valid ? mem_q[rd_ptr_q] : 10'd0;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_rx_fifo
// Brief    : Self-checking bench for ps2_kbd_rx_fifo against a byte-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx_fifo;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 2000;
  localparam int FIFO_DEPTH  = 8;
  localparam int CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int HALF        = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2_clk = 1'b1;
  logic          ps2_dat = 1'b1;
  logic          ev_ready = 1'b0;
  logic [7:0]    ev_code;
  logic          ev_break;
  logic          ev_ext;
  logic          ev_valid;
  logic          frame_err;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  ps2_kbd_rx_fifo #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .ev_code   (ev_code),
    .ev_break  (ev_break),
    .ev_ext    (ev_ext),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and reference model state
  logic [9:0] got[$];
  logic [9:0] exp_q[$];
  int         err_cnt = 0;
  int         m_err = 0;
  bit         m_ext = 0, m_brk = 0, m_hold = 0, m_ovf = 0;
  int         valid_rise_cyc = -1;
  int         stop_fall_cyc = 0;
  int         pulse_off = 0;
  int         pulse_cyc = -1;
  bit         rand_ready = 0;

  logic       prev_valid = 1'b0;
  logic       prev_hold = 1'b0;
  logic [9:0] prev_head = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_cnt++;
      if (ev_valid && !prev_valid) valid_rise_cyc = cyc;
      if (prev_hold && ev_valid) begin
        tests++;
        if ({ev_ext, ev_break, ev_code} !== prev_head) begin
          fails++;
          $display("FAIL head_stable: got %h want %h", {ev_ext, ev_break, ev_code}, prev_head);
        end
      end
      if (ev_valid && ev_ready) got.push_back({ev_ext, ev_break, ev_code});
    end
    prev_hold  = ev_valid && !ev_ready && !rst;
    prev_valid = ev_valid;
    prev_head  = {ev_ext, ev_break, ev_code};
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) ev_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d want done", cyc);
    $fatal(1);
  end

  // Keyboard-level behaviour: prefixes accumulate, a code emits one event.
  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (m_hold && exp_q.size() >= FIFO_DEPTH) m_ovf = 1;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  function automatic void model_err();
    m_err++;
    m_ext = 0;
    m_brk = 0;
  endfunction

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    if (pulse_cyc >= 0) begin
      if (cyc == pulse_cyc) ev_ready = 1'b1;
      else if (cyc == pulse_cyc + 1) begin
        ev_ready  = 1'b0;
        pulse_cyc = -1;
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bits(input logic [10:0] fr, input int nbits, input bit glitch);
    int g;
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      if (glitch) begin
        g = $urandom_range(1, FILTER_LEN - 1);
        ticks(8); ps2_clk = 1'b0; ticks(g); ps2_clk = 1'b1; ticks(HALF - 8 - g);
      end else begin
        ticks(HALF);
      end
      ps2_clk = 1'b0;
      if (i == 10) begin
        stop_fall_cyc = cyc;
        if (pulse_off > 0) pulse_cyc = cyc + pulse_off - 1;
      end
      ticks(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    ticks(2 * HALF);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bp, input bit bs, input bit gl);
    send_bits(make_frame(b, bp, bs), 11, gl);
    if (bp || bs) model_err();
    else model_byte(b);
  endtask

  task automatic clear_model();
    got.delete();
    exp_q.delete();
    err_cnt = 0;
    m_err = 0; m_ext = 0; m_brk = 0; m_hold = 0; m_ovf = 0;
    pulse_cyc = -1;
    pulse_off = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    ticks(4);
    rst = 1'b0;
    ticks(2);
    clear_model();
  endtask

  task automatic drain();
    int n = 0;
    while (got.size() < exp_q.size() && n < 5000) begin
      tick();
      n++;
    end
    ticks(10);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    ticks(4);
    tests++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
    tests++; if (fifo_count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    tests++;
    if ({ev_ext, ev_break, ev_code} !== 10'h000) begin
      fails++; $display("FAIL reset_head: got %h want 000", {ev_ext, ev_break, ev_code});
    end
    rst = 1'b0;
    ticks(2);
    clear_model();
  endtask

  task automatic test_single();
    clear_model();
    ev_ready = 1'b1;
    send_byte(8'h1C, 0, 0, 0);
    drain();
    tests++; if (got.size() != 1) begin fails++; $display("FAIL single_n: got %0d want 1", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        fails++; $display("FAIL single_ev[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 10'h3FF, exp_q[i]);
      end
    end
    tests++; if (fifo_count !== '0) begin fails++; $display("FAIL single_count: got %0d want 0", fifo_count); end
    tests++; if (err_cnt != m_err) begin fails++; $display("FAIL single_err: got %0d want %0d", err_cnt, m_err); end
  endtask

  task automatic test_prefix();
    clear_model();
    ev_ready = 1'b1;
    send_byte(8'hF0, 0, 0, 0);
    send_byte(8'h1C, 0, 0, 0);
    send_byte(8'hE0, 0, 0, 0);
    send_byte(8'hF0, 0, 0, 0);
    send_byte(8'h75, 0, 0, 0);
    drain();
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL prefix_n: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        fails++; $display("FAIL prefix_ev[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 10'h3FF, exp_q[i]);
      end
    end
  endtask

  task automatic test_parity_err();
    clear_model();
    ev_ready = 1'b1;
    send_byte(8'h1C, 1, 0, 0);
    send_byte(8'h32, 0, 0, 0);
    drain();
    tests++; if (err_cnt != m_err) begin fails++; $display("FAIL parity_err: got %0d want %0d", err_cnt, m_err); end
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL parity_n: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        fails++; $display("FAIL parity_ev[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 10'h3FF, exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    clear_model();
    ev_ready = 1'b1;
    send_byte(8'hE0, 0, 0, 0);
    send_bits(make_frame(8'h1C, 0, 0), 5, 0);
    model_err();
    ticks(TIMEOUT_CYC + 10);
    tests++; if (err_cnt != m_err) begin fails++; $display("FAIL timeout_err: got %0d want %0d", err_cnt, m_err); end
    send_byte(8'h1C, 0, 0, 0);
    drain();
    tests++; if (err_cnt != m_err) begin fails++; $display("FAIL timeout_err_after: got %0d want %0d", err_cnt, m_err); end
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL timeout_n: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        fails++; $display("FAIL timeout_ev[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 10'h3FF, exp_q[i]);
      end
    end
  endtask

  task automatic test_glitch();
    clear_model();
    ev_ready = 1'b1;
    ps2_dat = 1'b0;
    for (int k = 0; k < 12; k++) begin
      ticks(6);
      ps2_clk = 1'b0;
      ticks($urandom_range(1, FILTER_LEN - 1));
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    ticks(TIMEOUT_CYC + 10);
    tests++; if (err_cnt != m_err) begin fails++; $display("FAIL glitch_idle_err: got %0d want %0d", err_cnt, m_err); end
    tests++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL glitch_idle_valid: got %b want 0", ev_valid); end
    send_byte(8'h5A, 0, 0, 1);
    send_byte(8'($urandom_range(1, 127)), 0, 0, 1);
    drain();
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL glitch_n: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        fails++; $display("FAIL glitch_ev[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 10'h3FF, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_model();
    ev_ready = 1'b0;
    send_byte(8'h2B, 0, 0, 0);
    send_byte(8'hE0, 0, 0, 0);
    send_bits(make_frame(8'h44, 0, 0), 4, 0);
    rst = 1'b1;
    ticks(3);
    tests++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", ev_valid); end
    tests++; if (fifo_count !== '0) begin fails++; $display("FAIL midrst_count: got %0d want 0", fifo_count); end
    tests++;
    if ({ev_ext, ev_break, ev_code} !== 10'h000) begin
      fails++; $display("FAIL midrst_head: got %h want 000", {ev_ext, ev_break, ev_code});
    end
    rst = 1'b0;
    ticks(1);
    clear_model();
    ticks(TIMEOUT_CYC + 10);
    tests++; if (err_cnt != 0) begin fails++; $display("FAIL midrst_err: got %0d want 0", err_cnt); end
    ev_ready = 1'b1;
    send_byte(8'h1C, 0, 0, 0);
    drain();
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL midrst_n: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        fails++; $display("FAIL midrst_ev[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 10'h3FF, exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ev_ready = 1'b0;
    m_hold = 1;
    for (int c = 1; c <= FIFO_DEPTH + 1; c++) send_byte(8'(c), 0, 0, 0);
    tests++; if (fifo_count !== CW'(exp_q.size())) begin fails++; $display("FAIL ovf_count: got %0d want %0d", fifo_count, exp_q.size()); end
    tests++; if (overflow !== m_ovf) begin fails++; $display("FAIL ovf_flag: got %b want %b", overflow, m_ovf); end
    m_hold = 0;
    ev_ready = 1'b1;
    drain();
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL ovf_n: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        fails++; $display("FAIL ovf_order[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 10'h3FF, exp_q[i]);
      end
    end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_reset();
    ev_ready = 1'b0;
    valid_rise_cyc = -1;
    send_byte(8'h11, 0, 0, 0);
    lat = valid_rise_cyc - stop_fall_cyc;
    tests++;
    if (valid_rise_cyc < 0 || lat < 1 || lat >= HALF) begin
      fails++; $display("FAIL b2b_latency: got %0d want 1..%0d", lat, HALF - 1);
    end
    do_reset();
    ev_ready = 1'b0;
    m_hold = 1;
    for (int c = 0; c < FIFO_DEPTH; c++) send_byte(8'h21 + 8'(c), 0, 0, 0);
    tests++; if (fifo_count !== CW'(FIFO_DEPTH)) begin fails++; $display("FAIL b2b_full: got %0d want %0d", fifo_count, FIFO_DEPTH); end
    // Pop lands exactly in the push cycle, so the model sees room.
    m_hold = 0;
    pulse_off = lat;
    send_byte(8'h29, 0, 0, 0);
    pulse_off = 0;
    tests++; if (fifo_count !== CW'(FIFO_DEPTH)) begin fails++; $display("FAIL b2b_count: got %0d want %0d", fifo_count, FIFO_DEPTH); end
    tests++; if (overflow !== m_ovf) begin fails++; $display("FAIL b2b_overflow: got %b want %b", overflow, m_ovf); end
    tests++; if (got.size() != 1) begin fails++; $display("FAIL b2b_one_pop: got %0d want 1", got.size()); end
    ev_ready = 1'b1;
    drain();
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL b2b_n: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        fails++; $display("FAIL b2b_ev[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 10'h3FF, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] b;
    do_reset();
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 15) b = 8'hE0;
      else if (r < 30) b = 8'hF0;
      else b = 8'($urandom());
      send_byte(b, (r >= 30 && r < 38), (r >= 38 && r < 43), 0);
    end
    rand_ready = 0;
    tick();
    ev_ready = 1'b1;
    drain();
    tests++; if (err_cnt != m_err) begin fails++; $display("FAIL rand_err: got %0d want %0d", err_cnt, m_err); end
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL rand_n: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        fails++; $display("FAIL rand_ev[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 10'h3FF, exp_q[i]);
      end
    end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rand_overflow: got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity_err();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_overflow();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
